// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS-subset datapath
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   opcode, func, zero    IR fields from the decoder and the ALU zero flag
//   mem_ready             data memory handshake for MEMRD/MEMWR
//   pc_we..pc_sel         datapath enables and mux selects
//   instr_done, illegal,  single-cycle status pulses
//   mem_err
//   state                 current FSM state for debug
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic       ext_op,
    output logic [1:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [1:0] pc_sel,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXE    = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_WB     = 4'd6;
    localparam logic [3:0] S_BR     = 4'd7;
    localparam logic [3:0] S_JMP    = 4'd8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [3:0]       state_q, state_d;
    logic [5:0]       op_q, fn_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // IR is only guaranteed stable in DECODE, so decode live there and from the latch afterwards
    logic [5:0] op, fn;
    assign op = (state_q == S_DECODE) ? opcode : op_q;
    assign fn = (state_q == S_DECODE) ? func : fn_q;

    logic r_type, is_addu, is_subu, is_jr, is_nop, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, legal;
    assign r_type  = op == 6'b000000;
    assign is_addu = r_type && fn == 6'b100001;
    assign is_subu = r_type && fn == 6'b100011;
    assign is_jr   = r_type && fn == 6'b001000;
    assign is_nop  = r_type && fn == 6'b000000;
    assign is_ori  = op == 6'b001101;
    assign is_lui  = op == 6'b001111;
    assign is_lw   = op == 6'b100011;
    assign is_sw   = op == 6'b101011;
    assign is_beq  = op == 6'b000100;
    assign is_j    = op == 6'b000010;
    assign is_jal  = op == 6'b000011;
    assign legal   = is_addu | is_subu | is_jr | is_nop | is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal;

    logic in_mem, abort;
    assign in_mem = (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // a ready response in the last allowed cycle takes priority over the timeout
    assign abort  = (MEM_TIMEOUT != 0) && in_mem && !mem_ready && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (!legal || is_nop) ? S_FETCH :
                                (is_addu || is_subu || is_ori || is_lui) ? S_EXE :
                                (is_lw || is_sw) ? S_MEMADR :
                                is_beq ? S_BR : S_JMP;
            S_EXE:    state_d = S_WB;
            S_MEMADR: state_d = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_WB : abort ? S_FETCH : S_MEMRD;
            S_MEMWR:  state_d = (mem_ready || abort) ? S_FETCH : S_MEMWR;
            default:  state_d = S_FETCH;
        endcase
    end

    assign cnt_d = (state_q == S_MEMADR) ? '0 : (in_mem && !mem_ready) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                fn_q <= func;
            end
        end
    end

    assign state = state_q;

    // every control output is forced inactive while reset is held, regardless of state
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        alu_srca   = 1'b0;
        alu_srcb   = 2'd0;
        ext_op     = 1'b0;
        alu_op     = 2'd0;
        reg_dst    = 2'd0;
        wd_sel     = 2'd0;
        pc_sel     = 2'd0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_we    = 1'b1;
                    pc_we    = 1'b1;
                    alu_srcb = 2'd2;
                end
                S_DECODE: begin
                    alu_srcb   = 2'd3;
                    ext_op     = 1'b1;
                    instr_done = !legal || is_nop;
                    illegal    = !legal;
                end
                S_EXE: begin
                    alu_srca = 1'b1;
                    alu_srcb = is_ori ? 2'd1 : 2'd0;
                    alu_op   = is_subu ? 2'd1 : is_ori ? 2'd2 : 2'd0;
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                    reg_dst    = r_type ? 2'd1 : 2'd0;
                    wd_sel     = is_lui ? 2'd2 : is_lw ? 2'd1 : 2'd0;
                end
                S_MEMADR: begin
                    alu_srca = 1'b1;
                    alu_srcb = 2'd1;
                    ext_op   = 1'b1;
                end
                S_MEMRD: begin
                    mem_re     = 1'b1;
                    mem_err    = abort;
                    instr_done = abort;
                end
                S_MEMWR: begin
                    mem_we     = 1'b1;
                    mem_err    = abort;
                    instr_done = abort || mem_ready;
                end
                S_BR: begin
                    alu_srca   = 1'b1;
                    alu_op     = 2'd1;
                    pc_sel     = 2'd1;
                    pc_we      = zero;
                    instr_done = 1'b1;
                end
                S_JMP: begin
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    pc_sel     = is_jr ? 2'd3 : 2'd2;
                    reg_we     = is_jal;
                    reg_dst    = is_jal ? 2'd2 : 2'd0;
                    wd_sel     = is_jal ? 2'd3 : 2'd0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl with an instruction-level reference model
module tb_mc_ctrl;
    localparam int TO = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we, ir_we, reg_we, mem_re, mem_we, srca;
        logic [1:0] srcb;
        logic       ext;
        logic [1:0] aop, rdst, wds, psel;
        logic       done, ill, merr;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0, func = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       pc_we, ir_we, reg_we, mem_re, mem_we, alu_srca, ext_op;
    logic [1:0] alu_srcb, alu_op, reg_dst, wd_sel, pc_sel;
    logic       instr_done, illegal, mem_err;
    logic [3:0] state;

    mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .ext_op(ext_op), .alu_op(alu_op),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .pc_sel(pc_sel), .instr_done(instr_done),
        .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    ctl_t  sb[$];
    string lbl[$];
    int    checks = 0;
    int    errors = 0;

    ctl_t act;
    assign act = '{state, pc_we, ir_we, reg_we, mem_re, mem_we, alu_srca, alu_srcb, ext_op,
                   alu_op, reg_dst, wd_sel, pc_sel, instr_done, illegal, mem_err};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            ctl_t  e;
            string n;
            e = sb.pop_front();
            n = lbl.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h (state %0d want %0d)", n, act, e, state, e.st);
            end
        end
    end

    // instruction classes: 0 illegal 1 nop 2 addu 3 subu 4 jr 5 ori 6 lui 7 lw 8 sw 9 beq 10 j 11 jal
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000)
            return fn == 6'b100001 ? 2 : fn == 6'b100011 ? 3 : fn == 6'b001000 ? 4 : fn == 6'b000000 ? 1 : 0;
        case (op)
            6'b001101: return 5;
            6'b001111: return 6;
            6'b100011: return 7;
            6'b101011: return 8;
            6'b000100: return 9;
            6'b000010: return 10;
            6'b000011: return 11;
            default:   return 0;
        endcase
    endfunction

    function automatic ctl_t wb_word(input int k);
        ctl_t c = '0;
        c.st = 4'd6; c.reg_we = 1; c.done = 1;
        c.rdst = (k <= 4) ? 2'd1 : 2'd0;
        c.wds = (k == 6) ? 2'd2 : (k == 7) ? 2'd1 : 2'd0;
        return c;
    endfunction

    // builds the expected per-cycle control words for one instruction and drives it
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z, input int s);
        ctl_t c;
        ctl_t q[$];
        bit   r[$];
        int   k = classify(op, fn);
        c = '0; c.st = 4'd0; c.ir_we = 1; c.pc_we = 1; c.srcb = 2'd2;
        q.push_back(c); r.push_back(1'($urandom));
        c = '0; c.st = 4'd1; c.srcb = 2'd3; c.ext = 1;
        c.done = (k <= 1); c.ill = (k == 0);
        q.push_back(c); r.push_back(1'($urandom));
        if (k == 2 || k == 3 || k == 5 || k == 6) begin
            c = '0; c.st = 4'd2; c.srca = 1;
            c.srcb = (k == 5) ? 2'd1 : 2'd0;
            c.aop = (k == 3) ? 2'd1 : (k == 5) ? 2'd2 : 2'd0;
            q.push_back(c); r.push_back(1'($urandom));
            q.push_back(wb_word(k)); r.push_back(1'($urandom));
        end else if (k == 7 || k == 8) begin
            int n = (s < TO) ? s + 1 : TO;
            c = '0; c.st = 4'd3; c.srca = 1; c.srcb = 2'd1; c.ext = 1;
            q.push_back(c); r.push_back(1'($urandom));
            for (int i = 0; i < n; i++) begin
                bit rdy = (i >= s);
                bit ab = (s >= TO) && (i == n - 1);
                c = '0; c.st = (k == 7) ? 4'd4 : 4'd5;
                c.mem_re = (k == 7); c.mem_we = (k == 8);
                c.merr = ab; c.done = ab || (k == 8 && rdy);
                q.push_back(c); r.push_back(rdy);
            end
            if (k == 7 && s < TO) begin
                q.push_back(wb_word(k)); r.push_back(1'($urandom));
            end
        end else if (k == 9) begin
            c = '0; c.st = 4'd7; c.srca = 1; c.aop = 2'd1; c.psel = 2'd1; c.pc_we = z; c.done = 1;
            q.push_back(c); r.push_back(1'($urandom));
        end else if (k >= 10 || k == 4) begin
            c = '0; c.st = 4'd8; c.pc_we = 1; c.done = 1;
            c.psel = (k == 4) ? 2'd3 : 2'd2;
            if (k == 11) begin
                c.reg_we = 1; c.rdst = 2'd2; c.wds = 2'd3;
            end
            q.push_back(c); r.push_back(1'($urandom));
        end
        foreach (q[i]) begin
            sb.push_back(q[i]);
            lbl.push_back($sformatf("%s cyc%0d", name, i));
        end
        opcode = op; func = fn; zero = z;
        foreach (r[i]) begin
            mem_ready = r[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic hold_reset(input string name, input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            sb.push_back('0);
            lbl.push_back($sformatf("%s cyc%0d", name, i));
        end
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [5:0] ops [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
        logic [5:0] fns [11] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('0);
            lbl.push_back($sformatf("reset cyc%0d", i));
        end
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        run("addu", 6'h00, 6'h21, 0, 0);
        run("ori", 6'h0D, 6'h15, 0, 0);
        run("lw_stall3", 6'h23, 6'h00, 0, 3);
        run("sw_timeout", 6'h2B, 6'h00, 0, 50);
        run("beq_taken", 6'h04, 6'h00, 1, 0);
        run("beq_not", 6'h04, 6'h00, 0, 0);
        run("jal", 6'h03, 6'h00, 0, 0);
        run("jr", 6'h00, 6'h08, 0, 0);
        run("illegal_op", 6'h3F, 6'h00, 0, 0);
        run("illegal_fn", 6'h00, 6'h20, 0, 0);
        run("nop", 6'h00, 6'h00, 0, 0);
        run("subu", 6'h00, 6'h23, 0, 0);
        run("lui", 6'h0F, 6'h00, 0, 0);
        run("j", 6'h02, 6'h00, 0, 0);
        run("lw_timeout", 6'h23, 6'h00, 0, 4);
        run("sw_stall3", 6'h2B, 6'h00, 0, 3);
        // abandon an lw as it enters MEMADR: state must drop to FETCH without waiting for a clock edge
        begin
            ctl_t c;
            c = '0; c.st = 4'd0; c.ir_we = 1; c.pc_we = 1; c.srcb = 2'd2;
            sb.push_back(c); lbl.push_back("midreset fetch");
            c = '0; c.st = 4'd1; c.srcb = 2'd3; c.ext = 1;
            sb.push_back(c); lbl.push_back("midreset decode");
            opcode = 6'h23; func = 6'h00; mem_ready = 1'b1;
            repeat (2) @(posedge clk);
            #1 hold_reset("midreset hold", 2);
        end
        run("addu_after_reset", 6'h00, 6'h21, 0, 0);
        for (int n = 0; n < 80; n++) begin
            int pick = $urandom_range(0, 12);
            logic [5:0] op, fn;
            if (pick < 11) begin
                op = ops[pick]; fn = (op == 6'h00) ? fns[pick] : 6'($urandom);
            end else begin
                op = 6'($urandom); fn = 6'($urandom);
            end
            run($sformatf("rand%0d op%h fn%h", n, op, fn), op, fn, 1'($urandom), $urandom_range(0, 6));
        end
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending words want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
